fetch_decode_ctrl: RTL and testbench
====================================

Name: fetch_decode_ctrl

Overview:
- Multi-cycle fetch/decode/execute controller for the 16-bit CPU.
- Owns the PC and instruction register (IR).
- Sequences memory reads and writes, and splits the IR into raw fields (rsrc, rdst, imm, flag_type) for the register-index/immediate translation stage.
- Generates register-file write enable, ALU enable and write-back select, and resolves branches and jumps.

Parameters:
- ADDR_W, 16, PC and memory address width.
- RESET_PC, 16'h0000, PC value after reset.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_rdata  in  16  memory read data, valid the cycle after mem_re
- reg_src_data  in  16  register-file value selected by rsrc_field
- reg_dst_data  in  16  register-file value selected by rdst_field
- flag_z  in  1  ALU zero flag (PSR)
- flag_c  in  1  ALU carry flag (PSR)
- flag_n  in  1  ALU negative flag (PSR)
- mem_addr  out  ADDR_W  memory address
- mem_re  out  1  memory read strobe
- mem_we  out  1  memory write strobe
- mem_wdata  out  16  store data
- opcode  out  4  IR[15:12]
- rdst_field  out  4  IR[11:8]
- flag_type  out  4  IR[7:4] when opcode==4'b0100, else 4'b0000
- rsrc_field  out  4  IR[3:0]
- imm_field  out  8  IR[7:0]
- alu_en  out  1  ALU result valid for write-back
- reg_we  out  1  register-file write strobe (one cycle)
- wb_sel  out  1  0=ALU result, 1=mem_rdata
- pc  out  ADDR_W  current PC
- halted  out  1  controller stopped

Behaviour:
- Reset (async, rst_n=0): state=FETCH, pc=RESET_PC, IR=16'h0000, all strobes 0, wb_sel=0, halted=0, mem_wdata=0. Reset mid-instruction aborts it with no write; the first fetch follows 1 cycle after deassertion.
- FETCH: mem_addr=pc, mem_re=1 -> LATCH.
- LATCH: IR<=mem_rdata -> DECODE.
- DECODE: fields stable, no strobes -> EXEC, or HALT if opcode==4'b1111.
- EXEC, by opcode:
  - R-type 0000, or immediate ops 0001-1011 except 0100: alu_en=1, reg_we=1, wb_sel=0; pc<=pc+1 -> FETCH.
  - 0100, ext 0000 LOAD: -> MEM.
  - 0100, ext 1000 STOR: -> MEM.
  - 0100, ext 1100 Jcond: if cond true, pc<=reg_src_data[ADDR_W-1:0], else pc+1; no reg write -> FETCH.
  - 0100, other ext: treated as NOP, pc+1.
  - 1100 Bcond: if cond true, pc<=pc+sext(imm_field), else pc+1 -> FETCH.
  - 1101, 1110: NOP, pc+1.
- MEM:
  - LOAD: mem_addr=reg_src_data, mem_re=1 -> MEMWB.
  - STOR: mem_addr=reg_src_data, mem_wdata=reg_dst_data, mem_we=1 for exactly 1 cycle; pc<=pc+1 -> FETCH.
- MEMWB: reg_we=1, wb_sel=1; pc<=pc+1 -> FETCH.
- HALT: halted=1, all strobes 0; left only by reset.
- Condition code is rdst_field:
  - 0000 EQ (z)
  - 0001 NE (!z)
  - 0010 CS (c)
  - 0011 CC (!c)
  - 0100 MI (n)
  - 0101 PL (!n)
  - 1110 UC (always)
  - all others never taken
- Flags are sampled in EXEC.
- Arithmetic: PC arithmetic is modulo 2^ADDR_W, so pc=16'hFFFF+1 wraps to 0. Bcond displacement is 8-bit two's complement, sign-extended to ADDR_W.
- Latency per instruction:
  - ALU, branch, jump, NOP: 4 cycles
  - STOR: 5 cycles
  - LOAD: 6 cycles
- reg_we is never asserted for STOR, Jcond, Bcond or NOP.
- mem_re and mem_we are never asserted together.

Decomposition:
- Shared package cpu_isa_pkg holds:
  - opcode constants (OP_RTYPE=0000, OP_SPECIAL=0100, OP_BCOND=1100, OP_HALT=1111)
  - ext constants (EXT_LOAD=0000, EXT_STOR=1000, EXT_JCOND=1100)
  - condition-code constants
  - the state enum (FETCH, LATCH, DECODE, EXEC, MEM, MEMWB, HALT)
- One sub-module, cond_eval: combinational, takes cond[3:0] and z, c, n, and outputs taken.

Test Plan:
- Reset then release; memory word 0 = 16'h0102 (R-type) -> mem_re at cycle 1 with addr 0; reg_we pulses in cycle 4; pc=1 after.
- LOAD 16'h4503 with reg_src_data=16'h0040, mem[0x40]=16'hBEEF -> second mem_re with addr 0x40; reg_we=1 with wb_sel=1 in cycle 6; pc+1.
- STOR 16'h4283 with reg_src_data=16'h0010, reg_dst_data=16'h1234 -> mem_we=1 for one cycle with addr 0x10, wdata 0x1234; no reg_we.
- Bcond 16'hC0FE at pc=0x0005: with flag_z=1, pc=0x0003; with flag_z=0, pc=0x0006. Bcond 16'hCEFF at pc=16'hFFFF (UC) -> pc=16'hFFFE. Jcond UC 16'h4EC7 with reg_src_data=0x0100 -> pc=0x0100.
- rst_n dropped during MEM of a STOR -> no mem_we; pc=RESET_PC; state FETCH.
- HALT 16'hF000 -> halted=1, no further mem_re for 20 cycles; reset clears halted.

Source files
------------

// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the 16-bit CPU control path.
// Contents: opcode, SPECIAL-group extension and condition-code constants,
// the fetch/decode/execute state enum, and a helper that classifies ALU opcodes.
package cpu_isa_pkg;

  localparam logic [3:0] OP_RTYPE   = 4'b0000;
  localparam logic [3:0] OP_SPECIAL = 4'b0100;
  localparam logic [3:0] OP_BCOND   = 4'b1100;
  localparam logic [3:0] OP_HALT    = 4'b1111;

  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b1000;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_CS = 4'b0010;
  localparam logic [3:0] CC_CC = 4'b0011;
  localparam logic [3:0] CC_MI = 4'b0100;
  localparam logic [3:0] CC_PL = 4'b0101;
  localparam logic [3:0] CC_UC = 4'b1110;

  typedef enum logic [2:0] {
    FETCH, LATCH, DECODE, EXEC, MEM, MEMWB, HALT
  } state_t;

  // R-type plus the immediate ALU ops 0001-1011; 0100 is the SPECIAL group.
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op <= 4'd11) && (op != OP_SPECIAL);
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Branch/jump condition evaluator.
// Ports: cond - condition code (rdst field); z/c/n - PSR flags;
//        taken - 1 when the condition holds. Unlisted codes are never taken.
module cond_eval
  import cpu_isa_pkg::*;
(
  input  logic [3:0] cond,
  input  logic       z,
  input  logic       c,
  input  logic       n,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      CC_EQ:   taken = z;
      CC_NE:   taken = !z;
      CC_CS:   taken = c;
      CC_CC:   taken = !c;
      CC_MI:   taken = n;
      CC_PL:   taken = !n;
      CC_UC:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_decode_ctrl.sv
// Multi-cycle fetch/decode/execute controller. Owns PC and IR, sequences
// memory reads/writes, splits IR into raw fields and drives write-back control.
// Ports: clk/rst_n; mem_rdata (IR / load data, valid cycle after mem_re);
//   reg_src_data/reg_dst_data (register values for rsrc/rdst); flag_z/c/n;
//   mem_addr/mem_re/mem_we/mem_wdata; opcode/rdst_field/flag_type/rsrc_field/
//   imm_field; alu_en/reg_we/wb_sel; pc; halted.
module fetch_decode_ctrl
  import cpu_isa_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       mem_rdata,
  input  logic [15:0]       reg_src_data,
  input  logic [15:0]       reg_dst_data,
  input  logic              flag_z,
  input  logic              flag_c,
  input  logic              flag_n,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [15:0]       mem_wdata,
  output logic [3:0]        opcode,
  output logic [3:0]        rdst_field,
  output logic [3:0]        flag_type,
  output logic [3:0]        rsrc_field,
  output logic [7:0]        imm_field,
  output logic              alu_en,
  output logic              reg_we,
  output logic              wb_sel,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  state_t            state, state_nxt;
  logic              run;      // low for the first cycle after reset release
  logic [15:0]       ir;
  logic [ADDR_W-1:0] pc_nxt, pc_inc, br_tgt;
  logic [3:0]        ext;
  logic              taken, mem_op;

  assign opcode     = ir[15:12];
  assign rdst_field = ir[11:8];
  assign ext        = ir[7:4];
  assign rsrc_field = ir[3:0];
  assign imm_field  = ir[7:0];
  assign flag_type  = (opcode == OP_SPECIAL) ? ext : 4'b0000;

  assign mem_op = (opcode == OP_SPECIAL) && (ext == EXT_LOAD || ext == EXT_STOR);
  assign pc_inc = pc + ADDR_W'(1);
  assign br_tgt = pc + {{(ADDR_W-8){imm_field[7]}}, imm_field};

  cond_eval u_cond (
    .cond  (rdst_field),
    .z     (flag_z),
    .c     (flag_c),
    .n     (flag_n),
    .taken (taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 1'b0;
      pc  <= RESET_PC;
      ir  <= 16'h0000;
    end else begin
      run <= 1'b1;
      pc  <= pc_nxt;
      if (state == LATCH) ir <= mem_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   state_nxt = run ? LATCH : FETCH;
      LATCH:   state_nxt = DECODE;
      DECODE:  state_nxt = (opcode == OP_HALT) ? HALT : EXEC;
      EXEC:    state_nxt = mem_op ? MEM : FETCH;
      MEM:     state_nxt = (ext == EXT_LOAD) ? MEMWB : FETCH;
      MEMWB:   state_nxt = FETCH;
      HALT:    state_nxt = HALT;
      default: state_nxt = FETCH;
    endcase
  end

  // PC update; LOAD/STOR hold the PC in EXEC and advance once the access is done.
  always_comb begin
    pc_nxt = pc;
    case (state)
      EXEC: begin
        if (opcode == OP_SPECIAL) begin
          if (ext == EXT_JCOND && taken) pc_nxt = reg_src_data[ADDR_W-1:0];
          else if (!mem_op)              pc_nxt = pc_inc;
        end else if (opcode == OP_BCOND) begin
          pc_nxt = taken ? br_tgt : pc_inc;
        end else begin
          pc_nxt = pc_inc;
        end
      end
      MEM:     if (ext == EXT_STOR) pc_nxt = pc_inc;
      MEMWB:   pc_nxt = pc_inc;
      default: pc_nxt = pc;
    endcase
  end

  always_comb begin
    mem_addr  = pc;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = 16'h0000;
    alu_en    = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = 1'b0;
    halted    = 1'b0;
    case (state)
      FETCH: mem_re = run;
      EXEC: begin
        if (is_alu_op(opcode)) begin
          alu_en = 1'b1;
          reg_we = 1'b1;
        end
      end
      MEM: begin
        mem_addr = reg_src_data[ADDR_W-1:0];
        if (ext == EXT_LOAD) begin
          mem_re = 1'b1;
        end else begin
          mem_we    = 1'b1;
          mem_wdata = reg_dst_data;
        end
      end
      MEMWB: begin
        reg_we = 1'b1;
        wb_sel = 1'b1;
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Self-checking bench for fetch_decode_ctrl: directed cases followed by random
// instructions, each compared cycle-by-cycle against an instruction-level model.
module tb_fetch_decode_ctrl;

  localparam logic [15:0] RST_PC = 16'h0000;
  localparam int K_ALU = 0, K_LOAD = 1, K_STOR = 2, K_JMP = 3, K_BR = 4, K_NOP = 5, K_HALT = 6;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [15:0] mem_rdata = '0, reg_src_data = '0, reg_dst_data = '0;
  logic        flag_z = 1'b0, flag_c = 1'b0, flag_n = 1'b0;
  logic [15:0] mem_addr, mem_wdata, pc;
  logic        mem_re, mem_we, alu_en, reg_we, wb_sel, halted;
  logic [3:0]  opcode, rdst_field, flag_type, rsrc_field;
  logic [7:0]  imm_field;

  fetch_decode_ctrl #(.ADDR_W(16), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .mem_rdata(mem_rdata),
    .reg_src_data(reg_src_data), .reg_dst_data(reg_dst_data),
    .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .opcode(opcode), .rdst_field(rdst_field), .flag_type(flag_type),
    .rsrc_field(rsrc_field), .imm_field(imm_field),
    .alu_en(alu_en), .reg_we(reg_we), .wb_sel(wb_sel), .pc(pc), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [65536];
  logic [15:0] pc_m;
  logic        last_re;
  logic [15:0] last_addr;
  int          n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit cond_true(input logic [3:0] cc, input bit z, input bit c, input bit n);
    case (cc)
      4'd0:    return z;
      4'd1:    return !z;
      4'd2:    return c;
      4'd3:    return !c;
      4'd4:    return n;
      4'd5:    return !n;
      4'd14:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int kind_of(input logic [15:0] ins);
    if (ins[15:12] == 4'hF) return K_HALT;
    if (ins[15:12] == 4'hC) return K_BR;
    if (ins[15:12] == 4'hD || ins[15:12] == 4'hE) return K_NOP;
    if (ins[15:12] == 4'h4) begin
      case (ins[7:4])
        4'h0:    return K_LOAD;
        4'h8:    return K_STOR;
        4'hC:    return K_JMP;
        default: return K_NOP;
      endcase
    end
    return K_ALU;
  endfunction

  // Memory model: read data appears the cycle after a sampled mem_re.
  task automatic step_clk();
    @(posedge clk); #1;
    mem_rdata = last_re ? mem[last_addr] : 16'h0000;
  endtask

  task automatic sample();
    @(negedge clk);
    last_re   = mem_re;
    last_addr = mem_addr;
  endtask

  task automatic release_reset();
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    pc_m = RST_PC; last_re = 1'b0; mem_rdata = '0;
  endtask

  // Runs one instruction from pc_m; abort_at >= 0 pulls reset at that cycle.
  task automatic run_instr(input logic [15:0] ins, input logic [15:0] src, input logic [15:0] dst,
                           input bit z, input bit c, input bit n, input int abort_at);
    int k, lat, d;
    logic [15:0] npc;
    logic [4:0]  exp_s;
    bit tk;
    k = kind_of(ins);
    mem[pc_m] = ins;
    reg_src_data = src; reg_dst_data = dst;
    flag_z = z; flag_c = c; flag_n = n;
    tk  = cond_true(ins[11:8], z, c, n);
    d   = int'(ins[7:0]);
    if (d > 127) d -= 256;
    npc = pc_m + 16'd1;
    lat = 4;
    case (k)
      K_LOAD: lat = 6;
      K_STOR: lat = 5;
      K_HALT: lat = 3;
      K_JMP:  if (tk) npc = src;
      K_BR:   if (tk) npc = 16'(int'(pc_m) + d);
      default: ;
    endcase
    for (int cyc = 0; cyc < lat; cyc++) begin
      if (cyc == abort_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_we", mem_we, 1'b0);
        check("abort_re", mem_re, 1'b0);
        check("abort_pc", pc, RST_PC);
        pc_m = RST_PC; last_re = 1'b0;
        return;
      end
      exp_s = 5'b00000;  // {mem_re, mem_we, reg_we, wb_sel, alu_en}
      if (cyc == 0)                 exp_s = 5'b10000;
      if (cyc == 3 && k == K_ALU)   exp_s = 5'b00101;
      if (cyc == 4 && k == K_LOAD)  exp_s = 5'b10000;
      if (cyc == 4 && k == K_STOR)  exp_s = 5'b01000;
      if (cyc == 5 && k == K_LOAD)  exp_s = 5'b00110;
      sample();
      check($sformatf("strobes ins=%h pc=%h cyc=%0d", ins, pc_m, cyc),
            {mem_re, mem_we, reg_we, wb_sel, alu_en}, exp_s);
      if (cyc == 0) check("fetch_addr", mem_addr, pc_m);
      if (cyc == 4 && (k == K_LOAD || k == K_STOR)) check("data_addr", mem_addr, src);
      if (cyc == 4 && k == K_STOR) check("store_wdata", mem_wdata, dst);
      if (cyc == 2)
        check($sformatf("fields ins=%h", ins),
              {opcode, rdst_field, flag_type, rsrc_field, imm_field},
              {ins[15:12], ins[11:8], (ins[15:12] == 4'h4) ? ins[7:4] : 4'h0, ins[3:0], ins[7:0]});
      step_clk();
    end
    if (k != K_HALT) pc_m = npc;
    check($sformatf("pc after ins=%h", ins), pc, pc_m);
  endtask

  initial begin
    logic [15:0] ins;
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i * 7);
    last_re = 1'b0; last_addr = '0; pc_m = RST_PC;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_strobes", {mem_re, mem_we, reg_we, wb_sel, alu_en, halted}, 6'b0);
    check("rst_pc", pc, RST_PC);
    check("rst_wdata", mem_wdata, 16'h0);
    check("rst_ir", {opcode, rdst_field, rsrc_field, imm_field}, 20'h0);
    release_reset();

    // Directed
    run_instr(16'h0102, 16'h0000, 16'h0000, 0, 0, 0, -1);   // R-type -> pc 1
    mem[16'h0040] = 16'hBEEF;
    run_instr(16'h4503, 16'h0040, 16'h0000, 0, 0, 0, -1);   // LOAD
    run_instr(16'h4283, 16'h0010, 16'h1234, 0, 0, 0, -1);   // STOR
    run_instr(16'h4EC7, 16'h0005, 16'h0000, 0, 0, 0, -1);   // JMP UC -> 5
    run_instr(16'hC0FE, 16'h0000, 16'h0000, 1, 0, 0, -1);   // BEQ taken -> 3
    run_instr(16'h4EC7, 16'h0005, 16'h0000, 0, 0, 0, -1);   // -> 5
    run_instr(16'hC0FE, 16'h0000, 16'h0000, 0, 0, 0, -1);   // BEQ not taken -> 6
    run_instr(16'h40C7, 16'h0200, 16'h0000, 0, 0, 0, -1);   // JEQ not taken -> 7
    run_instr(16'h4234, 16'h0000, 16'h0000, 0, 0, 0, -1);   // unknown ext: NOP
    run_instr(16'h1300, 16'h0000, 16'h0000, 0, 0, 0, -1);   // imm ALU op
    run_instr(16'hD000, 16'h0000, 16'h0000, 0, 0, 0, -1);   // NOP
    run_instr(16'h4EC7, 16'hFFFF, 16'h0000, 0, 0, 0, -1);   // -> FFFF
    run_instr(16'hCEFF, 16'h0000, 16'h0000, 0, 0, 0, -1);   // BUC -1 -> FFFE
    run_instr(16'h4EC7, 16'hFFFF, 16'h0000, 0, 0, 0, -1);   // -> FFFF
    run_instr(16'h0123, 16'h0000, 16'h0000, 0, 0, 0, -1);   // ALU wrap -> 0
    run_instr(16'h4EC7, 16'h0100, 16'h0000, 0, 0, 0, -1);   // -> 0100

    // Reset during the MEM cycle of a store
    run_instr(16'h4283, 16'h0010, 16'h1234, 0, 0, 0, 4);
    release_reset();
    run_instr(16'h0102, 16'h0000, 16'h0000, 0, 0, 0, -1);

    // Random instructions (HALT excluded)
    for (int i = 0; i < 300; i++) begin
      ins = 16'($urandom);
      ins[15:12] = 4'($urandom_range(0, 14));
      if (ins[15:12] == 4'h4) begin
        case ($urandom_range(0, 3))
          0: ins[7:4] = 4'h0;
          1: ins[7:4] = 4'h8;
          2: ins[7:4] = 4'hC;
          default: ;
        endcase
      end
      run_instr(ins, 16'($urandom), 16'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom), -1);
    end

    // HALT: stays stopped until reset
    run_instr(16'hF000, 16'h0000, 16'h0000, 0, 0, 0, -1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("halt cyc=%0d", i), {halted, mem_re, mem_we, reg_we}, 4'b1000);
    end
    rst_n = 1'b0;
    #1;
    check("halt_cleared", halted, 1'b0);
    release_reset();
    run_instr(16'h0102, 16'h0000, 16'h0000, 0, 0, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
